// File: rtl/core_pkg.sv
// Core-wide constants shared by the pipeline and its memory targets.
//   Xlen              : address width
//   Ilen              : instruction / data word width
//   MemRespMaxLatency : deepest response pipe a memory target may build
// Also carries the memory operation encoding and a latency range helper
// used by mem_responder.
package core_pkg;

    localparam int Xlen              = 32;
    localparam int Ilen              = 32;
    localparam int MemRespMaxLatency = 8;

    // Seed for the optional ready-stall LFSR in mem_responder.
    localparam logic [15:0] MemRespLfsrSeed = 16'hACE1;

    typedef enum logic {
        MemRead  = 1'b0,
        MemWrite = 1'b1
    } mem_op_e;

    function automatic bit mem_latency_ok(input int lat);
        return (lat >= 1) && (lat <= MemRespMaxLatency);
    endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-length response delay line for mem_responder.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset (clears valid bits and output data)
//   valid_i : load a new entry this cycle
//   data_i  : entry payload
//   valid_o : entry leaving the last stage (one-cycle pulse per entry)
//   data_o  : payload of the last stage; holds the most recent entry
// Each stage only captures data when its upstream valid is set, so the
// output keeps the last delivered word while idle. Intermediate data stages
// carry no reset; only the valid bits and the output stage do.
module mem_resp_pipe #(
    parameter int Width   = 32,
    parameter int Latency = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic [Latency-1:0] valid_q;
    logic [Width-1:0]   out_q;
    logic [Width-1:0]   last_d;
    logic               last_ld;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= valid_i;
            for (int i = 1; i < Latency; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    if (Latency > 1) begin : g_mid
        logic [Width-1:0] mid_q [Latency-1];

        always_ff @(posedge clk_i) begin
            if (valid_i) begin
                mid_q[0] <= data_i;
            end
            for (int i = 1; i < Latency - 1; i++) begin
                if (valid_q[i-1]) begin
                    mid_q[i] <= mid_q[i-1];
                end
            end
        end

        assign last_d  = mid_q[Latency-2];
        assign last_ld = valid_q[Latency-2];
    end else begin : g_direct
        assign last_d  = data_i;
        assign last_ld = valid_i;
    end

    // The output stage is reset so rdata_o starts from a known zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q <= '0;
        end else if (last_ld) begin
            out_q <= last_d;
        end
    end

    assign valid_o = valid_q[Latency-1];
    assign data_o  = out_q;

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory target for the core's instmem_*/datamem_* ports.
// Accepts reads and byte-masked writes on a valid/ready handshake and returns
// one in-order response per accepted request exactly Latency cycles later.
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset (array contents are kept)
//   ready_o  : request can be accepted this cycle
//   valid_i  : request present
//   addr_i   : byte address; word index = addr_i[DepthLog2+1:2], rest ignored
//   wdata_i  : write data
//   wmask_i  : byte write enables; all-zero means read
//   rdata_o  : response data (post-write word for writes), held while idle
//   rvalid_o : one-cycle response pulse
// Optional build macro MEM_RESPONDER_STALL_EN: a 16-bit LFSR gates ready_o
// so it is high roughly one cycle in four, to exercise initiator backpressure.
module mem_responder #(
    parameter int    Xlen      = core_pkg::Xlen,
    parameter int    Ilen      = core_pkg::Ilen,
    parameter int    DepthLog2 = 12,
    parameter int    Latency   = 1,
    parameter string InitFile  = ""
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              ready_o,
    input  logic              valid_i,
    input  logic [Xlen-1:0]   addr_i,
    input  logic [Ilen-1:0]   wdata_i,
    input  logic [Ilen/8-1:0] wmask_i,
    output logic [Ilen-1:0]   rdata_o,
    output logic              rvalid_o
);

    import core_pkg::*;

    if (!mem_latency_ok(Latency)) begin : g_bad_latency
        $error("mem_responder: Latency %0d outside 1..%0d", Latency, MemRespMaxLatency);
    end

    logic [Ilen-1:0]      mem_q [2**DepthLog2];
    logic [DepthLog2-1:0] idx;
    logic [Ilen-1:0]      rd_word;
    logic [Ilen-1:0]      wr_word;
    mem_op_e              op;
    logic                 accept;
    logic                 ready_q;
    logic                 gate_ok;
    logic                 unused_addr;

    assign idx         = addr_i[DepthLog2+1:2];
    assign unused_addr = ^{addr_i[Xlen-1:DepthLog2+2], addr_i[1:0]};
    assign op          = (wmask_i != '0) ? MemWrite : MemRead;
    assign rd_word     = mem_q[idx];

    // Post-write view of the word; equals the stored word for reads.
    always_comb begin
        wr_word = rd_word;
        for (int b = 0; b < Ilen / 8; b++) begin
            if (wmask_i[b]) begin
                wr_word[8*b +: 8] = wdata_i[8*b +: 8];
            end
        end
    end

    // Held low through reset, high from the first edge after release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

`ifdef MEM_RESPONDER_STALL_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    // Fibonacci taps 16,14,13,11.
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= MemRespLfsrSeed;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end

    assign gate_ok = !lfsr_q[0] && !lfsr_q[1];
`else
    assign gate_ok = 1'b1;
`endif

    // ready_o comes only from flops, so there is no valid_i -> ready_o path.
    assign ready_o = ready_q && gate_ok;
    assign accept  = valid_i && ready_o;

    always_ff @(posedge clk_i) begin
        if (accept && (op == MemWrite)) begin
            mem_q[idx] <= wr_word;
        end
    end

    mem_resp_pipe #(
        .Width   (Ilen),
        .Latency (Latency)
    ) u_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (accept),
        .data_i  (wr_word),
        .valid_o (rvalid_o),
        .data_o  (rdata_o)
    );

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int NDUT = 3;

`ifdef MEM_RESPONDER_STALL_EN
    localparam logic READY_FIRST = 1'b0;  // LFSR 16'h59C3 after first step
    localparam int   NRAND       = 1000;
`else
    localparam logic READY_FIRST = 1'b1;
    localparam int   NRAND       = 300;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] w;
        logic [3:0]  m;
        logic [31:0] e;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    localparam int NDIR = 19;
    localparam vec_t DIR [NDIR] = '{
        '{32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF},
        '{32'h0000_0010, 32'h0,        4'h0, 32'hDEADBEEF},
        '{32'h0000_0014, 32'h11223344, 4'hF, 32'h11223344},
        '{32'h0000_0014, 32'hAABBCCDD, 4'h5, 32'h11BB33DD},
        '{32'h0000_0014, 32'h0,        4'h0, 32'h11BB33DD},
        '{32'h0000_0000, 32'hCAFE0000, 4'hF, 32'hCAFE0000},
        '{32'h0000_0004, 32'hCAFE0001, 4'hF, 32'hCAFE0001},
        '{32'h0000_0008, 32'hCAFE0002, 4'hF, 32'hCAFE0002},
        '{32'h0000_000C, 32'hCAFE0003, 4'hF, 32'hCAFE0003},
        '{32'h0000_0000, 32'h0,        4'h0, 32'hCAFE0000},
        '{32'h0000_0004, 32'h0,        4'h0, 32'hCAFE0001},
        '{32'h0000_0008, 32'h0,        4'h0, 32'hCAFE0002},
        '{32'h0000_000C, 32'h0,        4'h0, 32'hCAFE0003},
        '{32'h0000_0040, 32'h00000005, 4'hF, 32'h00000005},
        '{32'h0000_0000, 32'h0,        4'h0, 32'h00000005},
        '{32'h0000_0043, 32'h0,        4'h0, 32'h00000005},
        '{32'h0000_0002, 32'h77665544, 4'h8, 32'h77000005},
        '{32'h1000_0000, 32'h0,        4'h0, 32'h77000005},
        '{32'h0000_000C, 32'h0,        4'h0, 32'hCAFE0003}
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wmask = '0;
    logic        rdy [NDUT];
    logic        rv  [NDUT];
    logic [31:0] rd  [NDUT];

    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    exp_t q [NDUT][$];

    logic        duty_en = 1'b0;
    int          duty_hi = 0;
    int          duty_tot = 0;
    logic [31:0] ref_mem [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.DepthLog2(4), .Latency(1)) u_l1 (
        .clk_i(clk), .rst_i(rst), .ready_o(rdy[0]), .valid_i(valid), .addr_i(addr),
        .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rd[0]), .rvalid_o(rv[0]));

    mem_responder #(.DepthLog2(4), .Latency(3)) u_l3 (
        .clk_i(clk), .rst_i(rst), .ready_o(rdy[1]), .valid_i(valid), .addr_i(addr),
        .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rd[1]), .rvalid_o(rv[1]));

    mem_responder #(.DepthLog2(4), .Latency(4)) u_l4 (
        .clk_i(clk), .rst_i(rst), .ready_o(rdy[2]), .valid_i(valid), .addr_i(addr),
        .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rd[2]), .rvalid_o(rv[2]));

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic check32(input string name, input int k, input logic [31:0] act,
                           input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s dut%0d (cycle %0d): got %h, expected %h", name, k, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int k, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s dut%0d: got %0d, expected %0d", name, k, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation per observed rvalid pulse.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NDUT; k++) begin
                exp_t e;
                if (rv[k]) begin
                    if (q[k].size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL unexpected_rvalid dut%0d: rvalid 1 at cycle %0d, expected 0", k, cyc);
                    end else begin
                        e = q[k].pop_front();
                        check32("rdata", k, rd[k], e.data);
                        check_int("rvalid_cycle", k, cyc, e.due);
                    end
                end else if (q[k].size() > 0 && q[k][0].due < cyc) begin
                    e = q[k].pop_front();
                    n_vec++;
                    n_miss++;
                    $display("FAIL missing_rvalid dut%0d: none by cycle %0d, expected at cycle %0d",
                             k, cyc, e.due);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (duty_en) begin
            duty_tot++;
            if (rdy[0]) duty_hi++;
        end
    end

    // Called at a negedge; returns at the following negedge once accepted.
    task automatic req(input logic [31:0] a, input logic [31:0] w, input logic [3:0] m,
                       input logic [31:0] e);
        int   waited;
        exp_t x;
        waited = 0;
        valid  = 1'b1;
        addr   = a;
        wdata  = w;
        wmask  = m;
        while (!rdy[0]) begin
            waited++;
            if (waited > 200) begin
                n_vec++;
                n_miss++;
                $display("FAIL ready_timeout: ready_o still 0 after %0d cycles, expected 1", waited);
                valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
`ifndef MEM_RESPONDER_STALL_EN
        check32("ready_const", 1, {31'b0, rdy[1]}, 32'd1);
`endif
        for (int k = 0; k < NDUT; k++) begin
            x.data = e;
            x.due  = cyc + lat_of(k);
            q[k].push_back(x);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int t;
        valid = 1'b0;
        wmask = '0;
        t = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && t < 64) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < NDUT; k++) begin
            if (q[k].size() != 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL drain_timeout dut%0d: %0d responses outstanding, expected 0", k, q[k].size());
                q[k].delete();
            end
        end
    endtask

    // Responses due at or after the reset edge are discarded by the DUT.
    task automatic flush_on_reset(input int edge_cyc);
        exp_t e;
        for (int k = 0; k < NDUT; k++) begin
            while (q[k].size() != 0) begin
                e = q[k].pop_front();
                if (e.due < edge_cyc) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL missing_rvalid dut%0d: due at cycle %0d, never seen", k, e.due);
                end
            end
        end
    endtask

    initial begin
        logic [31:0] a, w, e;
        logic [3:0]  m;
        logic [3:0]  ix;

        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check32("reset_ready", k, {31'b0, rdy[k]}, 32'd0);
            check32("reset_rvalid", k, {31'b0, rv[k]}, 32'd0);
            check32("reset_rdata", k, rd[k], 32'd0);
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) check32("ready_before_edge", k, {31'b0, rdy[k]}, 32'd0);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++)
            check32("ready_after_release", k, {31'b0, rdy[k]}, {31'b0, READY_FIRST});
        repeat (4) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) check32("idle_rvalid", k, {31'b0, rv[k]}, 32'd0);
        end

        for (int i = 0; i < NDIR; i++) req(DIR[i].a, DIR[i].w, DIR[i].m, DIR[i].e);
        drain();
        repeat (2) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check32("rdata_hold", k, rd[k], 32'hCAFE0003);
            check32("rvalid_idle", k, {31'b0, rv[k]}, 32'd0);
        end

        // Two reads in flight, then reset shortly after the second accept.
        req(32'h10, 32'h0, 4'h0, 32'hDEADBEEF);
        req(32'h14, 32'h0, 4'h0, 32'h11BB33DD);
        valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        flush_on_reset(cyc);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check32("midreset_rdata", k, rd[k], 32'd0);
            check32("midreset_ready", k, {31'b0, rdy[k]}, 32'd0);
        end
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) check32("rvalid_in_reset", k, {31'b0, rv[k]}, 32'd0);
        end
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) check32("rvalid_after_reset", k, {31'b0, rv[k]}, 32'd0);
        end
        req(32'h14, 32'h0, 4'h0, 32'h11BB33DD);
        req(32'h10, 32'h0, 4'h0, 32'hDEADBEEF);
        drain();

        // Random traffic against a word-array reference.
        duty_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            ref_mem[i] = w;
            req(32'(i * 4), w, 4'hF, w);
        end
        for (int n = 0; n < NRAND; n++) begin
            a  = $urandom;
            w  = $urandom;
            m  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            ix = a[5:2];
            e  = ref_mem[ix];
            for (int b = 0; b < 4; b++) begin
                if (m[b]) e[8*b +: 8] = w[8*b +: 8];
            end
            ref_mem[ix] = e;
            req(a, w, m, e);
            if ($urandom_range(0, 7) == 0) begin
                valid = 1'b0;
                @(negedge clk);
            end
        end
        drain();
        duty_en = 1'b0;
`ifdef MEM_RESPONDER_STALL_EN
        n_vec++;
        if (duty_hi * 100 < duty_tot * 20 || duty_hi * 100 > duty_tot * 30) begin
            n_miss++;
            $display("FAIL ready_duty: %0d of %0d cycles ready, expected 20-30%%", duty_hi, duty_tot);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
